// File: rtl/imem_boot_sequencer.sv
// Instruction memory port owner: zero-fills the memory, accepts a streamed
// program image, then hands the port to the CPU fetch stage.
//
// state | meaning
// ------+--------------------------------------------------------------
// CLEAR | writing zero to every word, ptr walks 0..MEM_DEPTH-1
// LOAD  | accepting loader words at ptr until ld_last
// RUN   | CPU fetch owns the read port; reload restarts at CLEAR
module imem_boot_sequencer #(
  parameter int MEM_DEPTH = 1024,
  parameter int ADDR_W    = 10
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              fetch_req,
  input  logic [31:0]       fetch_addr,
  output logic [31:0]       fetch_inst,
  output logic              fetch_valid,
  output logic              fetch_misalign,
  input  logic              ld_valid,
  input  logic [31:0]       ld_data,
  input  logic              ld_last,
  output logic              ld_ready,
  input  logic              reload,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata,
  output logic              busy,
  output logic              ld_overflow,
  output logic [ADDR_W:0]   load_count
);

  typedef enum logic [1:0] {CLEAR, LOAD, RUN} state_t;

  localparam logic [ADDR_W-1:0] PTR_LAST = ADDR_W'(MEM_DEPTH - 1);
  localparam logic [ADDR_W:0]   CNT_FULL = (ADDR_W + 1)'(MEM_DEPTH);

  state_t            state, state_nx;
  logic [ADDR_W-1:0] ptr;
  logic              ptr_inc, ptr_clr;
  logic              cnt_inc, cnt_clr;
  logic              ovf_set, ovf_clr;

  // Fetch addresses above the memory wrap, so the upper bits are intentionally dropped.
  logic unused_fetch_hi;
  assign unused_fetch_hi = ^fetch_addr[31:ADDR_W+2];

  // State register; reset always restarts the zero-fill.
  always_ff @(posedge clk) begin
    if (reset) state <= CLEAR;
    else       state <= state_nx;
  end

  // Next-state, memory port steering and datapath controls.
  always_comb begin
    state_nx       = state;
    mem_we         = 1'b0;
    mem_addr       = ptr;
    mem_wdata      = '0;
    ld_ready       = 1'b0;
    fetch_valid    = 1'b0;
    fetch_misalign = 1'b0;
    fetch_inst     = mem_rdata;
    busy           = 1'b1;
    ptr_inc        = 1'b0;
    ptr_clr        = 1'b0;
    cnt_inc        = 1'b0;
    cnt_clr        = 1'b0;
    ovf_set        = 1'b0;
    ovf_clr        = 1'b0;
    case (state)
      CLEAR: begin
        mem_we  = 1'b1;
        ptr_inc = 1'b1;
        if (ptr == PTR_LAST) begin
          ptr_clr  = 1'b1;
          state_nx = LOAD;
        end
      end
      LOAD: begin
        ld_ready = 1'b1;
        if (ld_valid) begin
          // Once the memory is full, further words are dropped but ld_last still ends the load.
          if (load_count == CNT_FULL) begin
            ovf_set = 1'b1;
          end else begin
            mem_we    = 1'b1;
            mem_wdata = ld_data;
            ptr_inc   = 1'b1;
            cnt_inc   = 1'b1;
          end
          if (ld_last) state_nx = RUN;
        end
      end
      RUN: begin
        busy           = 1'b0;
        mem_addr       = fetch_addr[ADDR_W+1:2];
        fetch_valid    = fetch_req && (fetch_addr[1:0] == 2'b00);
        fetch_misalign = fetch_req && (fetch_addr[1:0] != 2'b00);
        if (reload) begin
          state_nx = CLEAR;
          ptr_clr  = 1'b1;
          cnt_clr  = 1'b1;
          ovf_clr  = 1'b1;
        end
      end
      default: state_nx = CLEAR;
    endcase
    // Keep the memory and handshakes quiet while reset is held, whatever state we were in.
    if (reset) begin
      mem_we         = 1'b0;
      ld_ready       = 1'b0;
      fetch_valid    = 1'b0;
      fetch_misalign = 1'b0;
      busy           = 1'b1;
    end
  end

  // Write pointer, word counter and sticky overflow flag.
  always_ff @(posedge clk) begin
    if (reset) begin
      ptr         <= '0;
      load_count  <= '0;
      ld_overflow <= 1'b0;
    end else begin
      if (ptr_clr)      ptr <= '0;
      else if (ptr_inc) ptr <= ptr + ADDR_W'(1);
      if (cnt_clr)      load_count <= '0;
      else if (cnt_inc) load_count <= load_count + (ADDR_W + 1)'(1);
      if (ovf_clr)      ld_overflow <= 1'b0;
      else if (ovf_set) ld_overflow <= 1'b1;
    end
  end

endmodule

// File: tb/tb_imem_boot_sequencer.sv
// Directed bench for imem_boot_sequencer with a behavioural instruction memory.
module tb_imem_boot_sequencer;

  logic        clk;
  logic        reset;
  logic        fetch_req;
  logic [31:0] fetch_addr;
  logic [31:0] fetch_inst;
  logic        fetch_valid;
  logic        fetch_misalign;
  logic        ld_valid;
  logic [31:0] ld_data;
  logic        ld_last;
  logic        ld_ready;
  logic        reload;
  logic        mem_we;
  logic [9:0]  mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        busy;
  logic        ld_overflow;
  logic [10:0] load_count;

  logic [31:0] mem_array [1024];
  int n_assert = 0;
  int n_fail   = 0;

  imem_boot_sequencer #(.MEM_DEPTH(1024), .ADDR_W(10)) dut (
    .clk(clk), .reset(reset),
    .fetch_req(fetch_req), .fetch_addr(fetch_addr), .fetch_inst(fetch_inst),
    .fetch_valid(fetch_valid), .fetch_misalign(fetch_misalign),
    .ld_valid(ld_valid), .ld_data(ld_data), .ld_last(ld_last), .ld_ready(ld_ready),
    .reload(reload),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .busy(busy), .ld_overflow(ld_overflow), .load_count(load_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory: synchronous write, asynchronous read.
  always @(posedge clk) if (mem_we) mem_array[mem_addr] <= mem_wdata;
  assign mem_rdata = mem_array[mem_addr];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // Walk the full zero-fill, checking every write.
  task automatic run_clear();
    for (int i = 0; i < 1024; i++) begin
      #1;
      chk("clr_we", {31'd0, mem_we}, 32'd1);
      chk("clr_addr", {22'd0, mem_addr}, i);
      chk("clr_wdata", mem_wdata, 32'd0);
      chk("clr_busy", {31'd0, busy}, 32'd1);
      chk("clr_ready", {31'd0, ld_ready}, 32'd0);
      chk("clr_fvalid", {31'd0, fetch_valid}, 32'd0);
      chk("clr_fmis", {31'd0, fetch_misalign}, 32'd0);
      tick();
    end
  endtask

  task automatic load_word(input logic [31:0] d, input logic last,
                           input logic exp_we, input logic [9:0] exp_addr);
    ld_valid = 1'b1;
    ld_data  = d;
    ld_last  = last;
    #1;
    chk("ld_ready", {31'd0, ld_ready}, 32'd1);
    chk("ld_we", {31'd0, mem_we}, {31'd0, exp_we});
    if (exp_we) begin
      chk("ld_addr", {22'd0, mem_addr}, {22'd0, exp_addr});
      chk("ld_wdata", mem_wdata, d);
    end
    tick();
    ld_valid = 1'b0;
    ld_last  = 1'b0;
  endtask

  task automatic idle(input logic [9:0] exp_addr);
    #1;
    chk("idle_we", {31'd0, mem_we}, 32'd0);
    chk("idle_addr", {22'd0, mem_addr}, {22'd0, exp_addr});
    tick();
  endtask

  task automatic fetch(input logic [31:0] a, input logic [31:0] exp_inst);
    fetch_req  = 1'b1;
    fetch_addr = a;
    #1;
    chk("f_valid", {31'd0, fetch_valid}, 32'd1);
    chk("f_mis", {31'd0, fetch_misalign}, 32'd0);
    chk("f_inst", fetch_inst, exp_inst);
  endtask

  initial begin
    reset = 1'b1; fetch_req = 1'b0; fetch_addr = '0;
    ld_valid = 1'b0; ld_data = '0; ld_last = 1'b0; reload = 1'b0;
    tick();
    chk("rst_ready", {31'd0, ld_ready}, 32'd0);
    chk("rst_fvalid", {31'd0, fetch_valid}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd1);
    chk("rst_we", {31'd0, mem_we}, 32'd0);
    chk("rst_cnt", {21'd0, load_count}, 32'd0);
    chk("rst_ovf", {31'd0, ld_overflow}, 32'd0);
    reset = 1'b0;

    // Zero-fill then ld_ready on cycle 1025
    run_clear();
    #1;
    chk("ready_rise", {31'd0, ld_ready}, 32'd1);
    chk("load_busy", {31'd0, busy}, 32'd1);

    // Three-word image
    load_word(32'h00500093, 1'b0, 1'b1, 10'd0);
    load_word(32'h00100113, 1'b0, 1'b1, 10'd1);
    load_word(32'h002081B3, 1'b1, 1'b1, 10'd2);
    #1;
    chk("run_busy", {31'd0, busy}, 32'd0);
    chk("run_ready", {31'd0, ld_ready}, 32'd0);
    chk("cnt3", {21'd0, load_count}, 32'd3);
    fetch(32'h8, 32'h002081B3);
    chk("f8_addr", {22'd0, mem_addr}, 32'd2);
    fetch(32'h0, 32'h00500093);
    fetch(32'h4, 32'h00100113);

    // Reload: the fetch in the reload cycle is still served
    reload = 1'b1;
    fetch(32'h8, 32'h002081B3);
    tick();
    reload = 1'b0; fetch_req = 1'b0;
    chk("reload_cnt", {21'd0, load_count}, 32'd0);
    run_clear();

    // Stalled stream; reload in LOAD is ignored
    idle(10'd0);
    load_word(32'hAAAA0001, 1'b0, 1'b1, 10'd0);
    reload = 1'b1;
    idle(10'd1);
    reload = 1'b0;
    #1;
    chk("reload_ign_busy", {31'd0, busy}, 32'd1);
    chk("reload_ign_ready", {31'd0, ld_ready}, 32'd1);
    idle(10'd1);
    load_word(32'hAAAA0002, 1'b0, 1'b1, 10'd1);
    idle(10'd2);
    load_word(32'hAAAA0003, 1'b1, 1'b1, 10'd2);
    chk("stall_cnt", {21'd0, load_count}, 32'd3);
    fetch(32'h0, 32'hAAAA0001);
    fetch(32'h4, 32'hAAAA0002);
    fetch(32'h8, 32'hAAAA0003);
    fetch(32'hC, 32'h00000000);

    // Overflowing image of 1025 words
    reload = 1'b1;
    tick();
    reload = 1'b0; fetch_req = 1'b0;
    run_clear();
    for (int i = 0; i < 1024; i++)
      load_word(32'h10000000 + i, 1'b0, 1'b1, 10'(i));
    chk("ovf_before", {31'd0, ld_overflow}, 32'd0);
    chk("cnt_full", {21'd0, load_count}, 32'd1024);
    load_word(32'hDEADBEEF, 1'b1, 1'b0, 10'd0);
    #1;
    chk("ovf_set", {31'd0, ld_overflow}, 32'd1);
    chk("ovf_cnt", {21'd0, load_count}, 32'd1024);
    chk("ovf_run", {31'd0, busy}, 32'd0);
    fetch(32'h0, 32'h10000000);

    // Misalign and address wrap
    fetch_req = 1'b1; fetch_addr = 32'h6;
    #1;
    chk("mis_flag", {31'd0, fetch_misalign}, 32'd1);
    chk("mis_valid", {31'd0, fetch_valid}, 32'd0);
    fetch(32'h1004, 32'h10000001);
    chk("wrap_addr", {22'd0, mem_addr}, 32'd1);
    fetch(32'hFFC, 32'h100003FF);
    fetch_req = 1'b0; fetch_addr = 32'h6;
    #1;
    chk("noreq_mis", {31'd0, fetch_misalign}, 32'd0);
    chk("noreq_valid", {31'd0, fetch_valid}, 32'd0);

    // Reload clears counters; CPU stalled during CLEAR
    reload = 1'b1;
    tick();
    reload = 1'b0;
    chk("rl_cnt", {21'd0, load_count}, 32'd0);
    chk("rl_ovf", {31'd0, ld_overflow}, 32'd0);
    fetch_req = 1'b1; fetch_addr = 32'h6;
    run_clear();
    fetch_req = 1'b0;

    // Reset mid-LOAD after five words
    for (int i = 0; i < 5; i++)
      load_word(32'h55000000 + i, 1'b0, 1'b1, 10'(i));
    chk("mid_cnt", {21'd0, load_count}, 32'd5);
    reset = 1'b1;
    tick();
    chk("midrst_we", {31'd0, mem_we}, 32'd0);
    chk("midrst_busy", {31'd0, busy}, 32'd1);
    chk("midrst_cnt", {21'd0, load_count}, 32'd0);
    reset = 1'b0;
    run_clear();

    // Single-word image with ld_last on the first word
    load_word(32'hCAFEF00D, 1'b1, 1'b1, 10'd0);
    #1;
    chk("one_busy", {31'd0, busy}, 32'd0);
    chk("one_cnt", {21'd0, load_count}, 32'd1);
    fetch(32'h0, 32'hCAFEF00D);
    fetch(32'h4, 32'h00000000);
    fetch_req = 1'b0;
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
